// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the write-back queue entry type.
package cpu_pkg;

    localparam int unsigned REG_BITS = 4;
    localparam int unsigned DBITS    = 32;
    localparam int unsigned NUM_REGS = 1 << REG_BITS;

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] idx;
        logic [DBITS-1:0]    data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_BITS-1:0] r);
        return NUM_REGS'(1) << r;
    endfunction

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Result-push handshake and regfile write-port bundle of the write-back queue.
interface regfile_wb_queue_if #(
    parameter int unsigned DBITS    = 32,
    parameter int unsigned REG_BITS = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [REG_BITS-1:0] in_reg;
    logic [DBITS-1:0]    in_data;
    logic                wr_en;
    logic [REG_BITS-1:0] wr_reg;
    logic [DBITS-1:0]    wr_data;

    modport master (
        output in_valid, in_reg, in_data,
        input  in_ready, wr_en, wr_reg, wr_data
    );

    modport slave (
        input  in_valid, in_reg, in_data,
        output in_ready, wr_en, wr_reg, wr_data
    );
endinterface

// File: rtl/wb_fwd_match.sv
// Age-ordered match of one read select against the queued write-back entries;
// the youngest matching entry supplies the forwarded value.
module wb_fwd_match
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  wb_entry_t                  entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [REG_BITS-1:0]        sel,
    output logic                       hit,
    output logic [DBITS-1:0]           data
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] p;

    // Walk oldest to youngest from head; later matches overwrite, so the youngest wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        p    = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            p = head + PW'(k);
            if (entries[p].valid && (entries[p].idx == sel)) begin
                hit  = 1'b1;
                data = entries[p].data;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue feeding the 16x32 dual-read register file: one drain per cycle,
// with forwarding of queued-but-unwritten values to both read selects.
module regfile_wb_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned DBITS    = cpu_pkg::DBITS,
    parameter int unsigned REG_BITS = cpu_pkg::REG_BITS
) (
    input  logic                       clk,
    input  logic                       reset,
    regfile_wb_queue_if.slave          bus,
    input  logic                       flush,
    input  logic [REG_BITS-1:0]        rd_sel1,
    input  logic [REG_BITS-1:0]        rd_sel2,
    output logic                       fwd_hit1,
    output logic [DBITS-1:0]           fwd_data1,
    output logic                       fwd_hit2,
    output logic [DBITS-1:0]           fwd_data2,
    output logic [(2**REG_BITS)-1:0]   busy_mask,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_entry_t     entries [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          push;
    logic          drain;

    // reset gates in_ready so the producer sees backpressure while reset is held
    assign bus.in_ready = reset && (count < CW'(DEPTH)) && !flush;
    assign bus.wr_en    = (count != '0) && !flush;
    assign bus.wr_reg   = entries[head].idx;
    assign bus.wr_data  = entries[head].data;

    assign push  = bus.in_valid && bus.in_ready;
    assign drain = bus.wr_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            // push and drain never address the same slot: drain needs count>0, push needs count<DEPTH
            if (push) begin
                entries[tail].valid <= 1'b1;
                entries[tail].idx   <= bus.in_reg;
                entries[tail].data  <= bus.in_data;
                tail                <= tail + PW'(1);
            end
            if (drain) begin
                entries[head].valid <= 1'b0;
                head                <= head + PW'(1);
            end
            if (push && !drain) begin
                count <= count + CW'(1);
            end else if (drain && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entries[i].valid) begin
                busy_mask = busy_mask | reg_onehot(entries[i].idx);
            end
        end
    end

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .entries (entries),
        .head    (head),
        .sel     (rd_sel1),
        .hit     (fwd_hit1),
        .data    (fwd_data1)
    );

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .entries (entries),
        .head    (head),
        .sel     (rd_sel2),
        .hit     (fwd_hit2),
        .data    (fwd_data2)
    );

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue: model queue checked against outputs every cycle.
module tb_regfile_wb_queue;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [3:0]  r;
        logic [31:0] d;
    } sb_item_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [3:0]  rd_sel1;
    logic [3:0]  rd_sel2;
    logic        fwd_hit1;
    logic [31:0] fwd_data1;
    logic        fwd_hit2;
    logic [31:0] fwd_data2;
    logic [15:0] busy_mask;
    logic [2:0]  count;

    int n_checks;
    int n_fail;
    int drains;
    sb_item_t q[$];

    regfile_wb_queue_if #(.DBITS(32), .REG_BITS(4)) bus ();

    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .bus       (bus),
        .flush     (flush),
        .rd_sel1   (rd_sel1),
        .rd_sel2   (rd_sel2),
        .fwd_hit1  (fwd_hit1),
        .fwd_data1 (fwd_data1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data2 (fwd_data2),
        .busy_mask (busy_mask),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [32:0] model_fwd(input logic [3:0] s);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].r == s) return {1'b1, q[i].d};
        end
        return '0;
    endfunction

    function automatic logic [15:0] model_busy();
        logic [15:0] m;
        m = '0;
        foreach (q[i]) m[q[i].r] = 1'b1;
        return m;
    endfunction

    // Compare current outputs against the model, then advance the model by the coming edge.
    always @(negedge clk) begin
        logic        exp_ready;
        logic        exp_wr;
        logic [32:0] f1;
        logic [32:0] f2;
        if (!rst_n) begin
            check_eq("rst_in_ready", bus.in_ready, 0);
            check_eq("rst_wr_en", bus.wr_en, 0);
            check_eq("rst_count", count, 0);
            check_eq("rst_busy", busy_mask, 0);
            check_eq("rst_fwd1", {fwd_hit1, fwd_data1}, 0);
            check_eq("rst_fwd2", {fwd_hit2, fwd_data2}, 0);
            q.delete();
        end else begin
            exp_ready = (q.size() < DEPTH) && !flush;
            exp_wr    = (q.size() != 0) && !flush;
            f1 = model_fwd(rd_sel1);
            f2 = model_fwd(rd_sel2);
            check_eq("in_ready", bus.in_ready, exp_ready);
            check_eq("wr_en", bus.wr_en, exp_wr);
            check_eq("count", count, q.size());
            check_eq("busy_mask", busy_mask, model_busy());
            check_eq("fwd1", {fwd_hit1, fwd_data1}, f1);
            check_eq("fwd2", {fwd_hit2, fwd_data2}, f2);
            if (exp_wr) begin
                check_eq("wr_reg", bus.wr_reg, q[0].r);
                check_eq("wr_data", bus.wr_data, q[0].d);
                void'(q.pop_front());
                drains++;
            end
            if (flush) begin
                q.delete();
            end else if (bus.in_valid && exp_ready) begin
                q.push_back('{r: bus.in_reg, d: bus.in_data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_push(input logic [3:0] r, input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.in_reg   = r;
        bus.in_data  = d;
    endtask

    initial begin
        int d0;
        rst_n        = 1'b0;
        flush        = 1'b0;
        rd_sel1      = '0;
        rd_sel2      = '0;
        bus.in_valid = 1'b0;
        bus.in_reg   = '0;
        bus.in_data  = '0;
        n_checks     = 0;
        n_fail       = 0;
        drains       = 0;

        repeat (3) tick();
        @(negedge clk);
        check_eq("hold_in_ready", bus.in_ready, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("release_in_ready", bus.in_ready, 1);

        // single push: visible on wr_* the cycle after acceptance, gone the cycle after
        tick();
        set_push(4'd5, 32'hDEADBEEF);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("single_wr_en", bus.wr_en, 1);
        check_eq("single_wr_reg", bus.wr_reg, 5);
        check_eq("single_wr_data", bus.wr_data, 32'hDEADBEEF);
        tick();
        @(negedge clk);
        check_eq("single_idle_wr_en", bus.wr_en, 0);
        check_eq("single_idle_count", count, 0);

        // continuous push with always-on drain holds count at 1
        tick();
        for (int i = 0; i < 5; i++) begin
            set_push(4'(i + 10), 32'h100 + 32'(i));
            @(negedge clk);
            if (i > 0) check_eq("burst_count", count, 1);
            tick();
        end

        // reset mid-traffic
        set_push(4'd1, 32'hAAAA0001);
        tick();
        rst_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_eq("midrst_count", count, 0);
        check_eq("midrst_wr_en", bus.wr_en, 0);
        check_eq("midrst_in_ready", bus.in_ready, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("midrst_release_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        repeat (2) tick();

        // forwarding: same register queued twice, youngest value wins
        rd_sel1 = 4'd3;
        rd_sel2 = 4'd4;
        set_push(4'd3, 32'h11);
        tick();
        set_push(4'd3, 32'h22);
        @(negedge clk);
        check_eq("fwd_first_data", fwd_data1, 32'h11);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("fwd_hit1", fwd_hit1, 1);
        check_eq("fwd_data1", fwd_data1, 32'h22);
        check_eq("fwd_hit2", fwd_hit2, 0);
        check_eq("fwd_data2", fwd_data2, 0);
        check_eq("fwd_busy", busy_mask, 16'h0008);
        repeat (2) tick();

        // wrap-around: ten pushes through a four-entry ring
        d0 = drains;
        for (int i = 0; i < 10; i++) begin
            set_push(4'(i), $urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (3) tick();
        check_eq("wrap_drains", drains - d0, 10);
        check_eq("wrap_count", count, 0);

        // flush with a pending entry and a producer still offering
        set_push(4'd7, 32'h77);
        tick();
        set_push(4'd8, 32'h88);
        flush = 1'b1;
        @(negedge clk);
        check_eq("flush_wr_en", bus.wr_en, 0);
        check_eq("flush_in_ready", bus.in_ready, 0);
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("postflush_count", count, 0);
        check_eq("postflush_wr_en", bus.wr_en, 0);
        repeat (2) tick();

        // randomized traffic with occasional flushes
        for (int i = 0; i < 200; i++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_reg   = 4'($urandom);
            bus.in_data  = $urandom;
            flush        = ($urandom_range(0, 15) == 0);
            rd_sel1      = 4'($urandom);
            rd_sel2      = 4'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
